// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
// Memory-side target of the system bus request/response protocol. Accepts
// line-sized writes (address beat + BEATS data beats) and reads (address beat,
// LATENCY wait, then a BEATS-beat response burst carrying the request tag).
// Optional feature macro: SYSBUS_MEM_CRITWORD_EN -- when defined, bursts start
// at word bus_req[5:3] of the line and wrap within it; otherwise at word 0.
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int BEATS          = 8,
    parameter int LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS);
    localparam int LW = AW - BW;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] WAIT_INIT = CW'(LATENCY);
    localparam logic [CW-1:0] WAIT_LAST = CW'(1);

    typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RRESP} state_t;

    state_t              state_reg;
    logic [LW-1:0]       line_reg;   // line index, wraps modulo the array
    logic [BW-1:0]       beat_reg;   // word offset within the line (wraps)
    logic [BW-1:0]       count_reg;  // beats transferred so far
    logic [CW-1:0]       wait_reg;   // read latency countdown
    logic [BUS_TAG_WIDTH-1:0] tag_reg;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [BW-1:0] start_beat;
    logic [BW-1:0] beat_inc;
    logic [AW-1:0] word_addr;
    logic [AW-1:0] next_addr;
    logic          mem_we;

`ifdef SYSBUS_MEM_CRITWORD_EN
    assign start_beat = bus_req[BW+2:3];
`else
    assign start_beat = '0;
`endif

    assign beat_inc  = beat_reg + 1'b1;
    assign word_addr = {line_reg, beat_reg};
    assign next_addr = {line_reg, beat_inc};

    // Requests are only taken while idle or collecting write data
    assign bus_reqack = reset && bus_reqcyc && ((state_reg == IDLE) || (state_reg == WDATA));
    assign mem_we     = bus_reqack && (state_reg == WDATA);

    // Word array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_addr] <= bus_req;
        end
    end

    // Protocol FSM; response data register doubles as the array's registered read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            line_reg    <= '0;
            beat_reg    <= '0;
            count_reg   <= '0;
            wait_reg    <= '0;
            tag_reg     <= '0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus_reqcyc) begin
                        line_reg  <= bus_req[AW+2:BW+3];
                        beat_reg  <= start_beat;
                        count_reg <= '0;
                        tag_reg   <= bus_reqtag;
                        if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                            state_reg <= RWAIT;
                            wait_reg  <= WAIT_INIT;
                        end else begin
                            state_reg <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (bus_reqcyc) begin
                        beat_reg  <= beat_inc;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_BEAT) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                RWAIT: begin
                    if (wait_reg == WAIT_LAST) begin
                        state_reg   <= RRESP;
                        bus_respcyc <= 1'b1;
                        bus_resp    <= mem[word_addr];
                        bus_resptag <= tag_reg;
                    end else begin
                        wait_reg <= wait_reg - 1'b1;
                    end
                end
                RRESP: begin
                    if (bus_respack) begin
                        if (count_reg == LAST_BEAT) begin
                            state_reg   <= IDLE;
                            bus_respcyc <= 1'b0;
                        end else begin
                            beat_reg  <= beat_inc;
                            count_reg <= count_reg + 1'b1;
                            bus_resp  <= mem[next_addr];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: a line-level memory model plus an expected
// response-beat queue, checked every negative edge, with directed bus sequences.
module tb_sysbus_mem_responder;
    localparam int DW        = 64;
    localparam int TW        = 13;
    localparam int MEM_WORDS = 4096;
    localparam int BEATS     = 8;
    localparam int LATENCY   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_mem [MEM_WORDS];
    logic [DW-1:0] exp_data_q[$];
    logic [TW-1:0] exp_tag_q[$];
    logic [DW-1:0] seen_q[$];

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_WORDS(MEM_WORDS),
        .BEATS(BEATS), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endfunction

    // Word index a given beat of a line request lands on
    function automatic int widx(input logic [63:0] addr, input int i);
        longint unsigned a;
        int line_no;
        int start;
        a = addr;
        line_no = int'((a >> 6) % 64'(MEM_WORDS / BEATS));
`ifdef SYSBUS_MEM_CRITWORD_EN
        start = int'((a >> 3) % 64'(BEATS));
`else
        start = 0;
`endif
        return line_no * BEATS + (start + i) % BEATS;
    endfunction

    // Every valid response beat must match the head of the expected queue
    always @(negedge clk) begin
        if (reset && bus_respcyc) begin
            if (exp_data_q.size() == 0) begin
                check("resp_unexpected", 64'(bus_respcyc), 64'(0));
            end else begin
                check("resp_data", bus_resp, exp_data_q[0]);
                check("resp_tag", 64'(bus_resptag), 64'(exp_tag_q[0]));
                if (bus_respack) begin
                    seen_q.push_back(bus_resp);
                    void'(exp_data_q.pop_front());
                    void'(exp_tag_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Present an address beat; returns after the accepting edge (+1)
    task automatic present_req(input logic [63:0] addr, input logic [TW-1:0] tag, output int waits);
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (bus_reqack) break;
            waits++;
            if (waits > 50) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus_reqcyc = 1'b0;
    endtask

    task automatic write_data(input logic [63:0] addr, input logic [63:0] base, input int stall_at);
        for (int i = 0; i < BEATS; i++) begin
            if (i == stall_at) begin
                bus_reqcyc = 1'b0;
                @(negedge clk);
                check("wdata_stall_no_ack", 64'(bus_reqack), 64'(0));
                @(posedge clk); #1;
            end
            bus_reqcyc = 1'b1;
            bus_req    = base + 64'(i);
            @(negedge clk);
            check("wdata_ack", 64'(bus_reqack), 64'(1));
            @(posedge clk); #1;
            model_mem[widx(addr, i)] = base + 64'(i);
        end
        bus_reqcyc = 1'b0;
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [63:0] base, input int stall_at);
        int waits;
        present_req(addr, 13'h0123, waits);
        check("write_ack_wait", 64'(waits), 64'(0));
        write_data(addr, base, stall_at);
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [TW-1:0] tag, input bit toggle,
                             input bit hold_w, input logic [63:0] waddr);
        int waits;
        int lat;
        int hs;
        int cyc;
        seen_q.delete();
        for (int i = 0; i < BEATS; i++) begin
            exp_data_q.push_back(model_mem[widx(addr, i)]);
            exp_tag_q.push_back(tag);
        end
        bus_respack = 1'b1;
        present_req(addr, tag, waits);
        check("read_ack_wait", 64'(waits), 64'(0));
        if (hold_w) begin
            bus_reqcyc = 1'b1;
            bus_req    = waddr;
            bus_reqtag = 13'h0042;
        end
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus_respcyc || lat > 50) break;
            if (hold_w) check("reqack_blocked_rwait", 64'(bus_reqack), 64'(0));
        end
        check("read_latency", 64'(lat), 64'(LATENCY + 1));
        hs = 0;
        cyc = 0;
        while (hs < BEATS && cyc < 64) begin
            if (hold_w) check("reqack_blocked_rresp", 64'(bus_reqack), 64'(0));
            if (bus_respcyc && bus_respack) hs++;
            @(posedge clk); #1;
            cyc++;
            bus_respack = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
        end
        check("read_handshakes", 64'(hs), 64'(BEATS));
        check("respcyc_drop", 64'(bus_respcyc), 64'(0));
        if (hold_w) check("held_write_ack", 64'(bus_reqack), 64'(1));
        @(posedge clk); #1;
        bus_respack = 1'b0;
    endtask

    task automatic check_seen(input string name, input int idx, input logic [63:0] exp);
        if (idx < seen_q.size()) check(name, seen_q[idx], exp);
        else check(name, 64'(seen_q.size()), 64'(idx + 1));
    endtask

    initial begin
        int waits;
        int hs;
        int cyc;
        reset       = 1'b0;
        bus_reqcyc  = 1'b1;
        bus_req     = 64'h1000;
        bus_reqtag  = 13'h1ABC;
        bus_respack = 1'b0;

        // Reset values, with a request presented to show reqack is forced low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_reqack", 64'(bus_reqack), 64'(0));
        check("reset_respcyc", 64'(bus_respcyc), 64'(0));
        check("reset_resp", bus_resp, 64'(0));
        check("reset_resptag", 64'(bus_resptag), 64'(0));
        bus_reqcyc = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("idle_no_req_no_ack", 64'(bus_reqack), 64'(0));
        @(posedge clk); #1;

        // Basic write (with one stall) then read back, ack tied high
        write_line(64'h1000, 64'h11, 3);
        read_line(64'h1000, 13'h1ABC, 1'b0, 1'b0, 64'h0);
        check_seen("lit_read_first", 0, 64'h11);
        check_seen("lit_read_last", 7, 64'h18);

        // Same line, respack toggling 1,0,1,0
        read_line(64'h1000, 13'h1ABC, 1'b1, 1'b0, 64'h0);
        check_seen("lit_toggle_beat3", 3, 64'h14);

        // Write held off during a read, accepted on the first idle cycle
        read_line(64'h1000, 13'h1F00, 1'b0, 1'b1, 64'h2000);
        write_data(64'h2000, 64'h21, -1);
        read_line(64'h2000, 13'h1001, 1'b0, 1'b0, 64'h0);
        check_seen("lit_held_write", 0, 64'h21);

        // Address wrap: write through the aliased address, read through the base one
        write_line(64'h3000 + 64'(MEM_WORDS * 8), 64'h31, -1);
        read_line(64'h3000, 13'h1234, 1'b0, 1'b0, 64'h0);
        check_seen("lit_wrap_first", 0, 64'h31);
        check_seen("lit_wrap_last", 7, 64'h38);

        // Critical-word ordering for reads and writes
        read_line(64'h1018, 13'h1555, 1'b0, 1'b0, 64'h0);
        write_line(64'h4010, 64'h41, -1);
        read_line(64'h4000, 13'h1666, 1'b0, 1'b0, 64'h0);
`ifdef SYSBUS_MEM_CRITWORD_EN
        check_seen("lit_crit_write_first", 0, 64'h47);
`else
        check_seen("lit_crit_write_first", 0, 64'h41);
`endif
        read_line(64'h1018, 13'h1555, 1'b0, 1'b0, 64'h0);
`ifdef SYSBUS_MEM_CRITWORD_EN
        check_seen("lit_crit_read_first", 0, 64'h14);
        check_seen("lit_crit_read_last", 7, 64'h13);
`else
        check_seen("lit_crit_read_first", 0, 64'h11);
        check_seen("lit_crit_read_last", 7, 64'h18);
`endif

        // Reset pulled low while beat 4 of a read is on the bus
        for (int i = 0; i < BEATS; i++) begin
            exp_data_q.push_back(model_mem[widx(64'h1000, i)]);
            exp_tag_q.push_back(13'h1ABC);
        end
        bus_respack = 1'b1;
        present_req(64'h1000, 13'h1ABC, waits);
        hs = 0;
        cyc = 0;
        while (hs < 4 && cyc < 64) begin
            @(negedge clk);
            if (bus_respcyc && bus_respack) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_beats_taken", 64'(hs), 64'(4));
        #2;
        reset      = 1'b0;
        bus_reqcyc = 1'b1;
        bus_req    = 64'h2000;
        bus_reqtag = 13'h1777;
        #1;
        check("abort_respcyc", 64'(bus_respcyc), 64'(0));
        check("abort_resp", bus_resp, 64'(0));
        check("abort_resptag", 64'(bus_resptag), 64'(0));
        check("abort_reqack", 64'(bus_reqack), 64'(0));
        exp_data_q.delete();
        exp_tag_q.delete();
        bus_respack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_reqcyc = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        read_line(64'h2000, 13'h1777, 1'b0, 1'b0, 64'h0);
        check_seen("lit_after_reset", 0, 64'h21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
